// File: rtl/mem_io_pkg.sv
// Shared constants and types for the CPU data-access controller:
// IO address map, controller states and requester identifiers.
package mem_io_pkg;

  localparam logic [19:0] IO_PREFIX    = 20'hFFFFF;
  localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_F000;
  localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_F010;
  localparam logic [31:0] NUM_ADDR_DEF = 32'hFFFF_F020;

  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;

  typedef logic req_id_t;
  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_LDR = 1'b1;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[31:12] == IO_PREFIX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the preferred requester wins a tie and
// preference passes to the other requester after every grant.
module rr_arb2
  import mem_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t pref;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    if (req[REQ_CPU] && req[REQ_LDR]) grant[pref] = 1'b1;
    else                              grant = req;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pref <= REQ_CPU;
    end else if (advance && (|grant)) begin
      pref <= grant[REQ_CPU] ? REQ_LDR : REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Shares the data memory between CPU and UART loader, owns the LED/switch/
// seven-segment IO registers, and stalls the CPU until each access completes.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [31:0] SW_ADDR  = SW_ADDR_DEF,
  parameter logic [31:0] NUM_ADDR = NUM_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        ldr_req,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  state_t      state, state_nxt;
  logic [31:0] lat_addr, lat_wdata, io_rdata;
  logic        lat_we;
  req_id_t     lat_id;
  logic [1:0]  grant;
  logic        advance, done, led_wr, num_wr;
  logic        lat_io, lat_cpu;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({ldr_req, cpu_req}),
    .advance (advance),
    .grant   (grant)
  );

  assign lat_io  = is_io_addr(lat_addr);
  assign lat_cpu = (lat_id == REQ_CPU);

  always_comb begin
    io_rdata = '0;
    if      (lat_addr == SW_ADDR)  io_rdata = {16'h0, sw_in};
    else if (lat_addr == LED_ADDR) io_rdata = {16'h0, led_out};
    else if (lat_addr == NUM_ADDR) io_rdata = num_out;
  end

  // Outputs are held at zero while reset is high so an abandoned access never acks.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    done      = 1'b0;
    led_wr    = 1'b0;
    num_wr    = 1'b0;
    cpu_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            advance   = 1'b1;
            state_nxt = ACC;
          end
        end
        ACC: begin
          if (!lat_io) begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            done      = lat_we;
            state_nxt = lat_we ? IDLE : WAIT;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
            if (lat_cpu && lat_we) begin
              led_wr = (lat_addr == LED_ADDR);
              num_wr = (lat_addr == NUM_ADDR);
            end else if (lat_cpu) begin
              cpu_rdata = io_rdata;
            end
          end
        end
        WAIT: begin
          done      = 1'b1;
          cpu_rdata = lat_cpu ? mem_rdata : '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cpu_ack   = done & lat_cpu;
  assign ldr_ack   = done & ~lat_cpu;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_id    <= REQ_CPU;
      led_out   <= '0;
      num_out   <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        if (grant[REQ_LDR]) begin
          lat_addr  <= ldr_addr;
          lat_wdata <= ldr_wdata;
          lat_we    <= 1'b1;
          lat_id    <= REQ_LDR;
        end else begin
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
          lat_we    <= cpu_we;
          lat_id    <= REQ_CPU;
        end
      end
      if (led_wr) led_out <= lat_wdata[15:0];
      if (num_wr) num_out <= lat_wdata;
    end
  end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Sequencing controller for the CPU data-access path. It shares the single-port, synchronous-read data memory between the CPU data port and the UART program loader, using round-robin arbitration. It also owns the memory-mapped IO registers (LED, switch, seven-segment number) and stalls the CPU until each access completes. It sits between the CPU load/store stage, the data memory and the board IO pins.

## Interface
Parameters:
- `LED_ADDR`, default 32'hFFFF_F000: LED register address (R/W).
- `SW_ADDR`, default 32'hFFFF_F010: switch input address (read-only).
- `NUM_ADDR`, default 32'hFFFF_F020: seven-segment value register (R/W).

Ports:
- `clk`  in  1  single clock; every register is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held stable until `cpu_ack`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid only while `cpu_ack` = 1, otherwise 0.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_ack`.
- `ldr_req`  in  1  loader write request; held until `ldr_ack`.
- `ldr_addr`  in  32  loader write address.
- `ldr_wdata`  in  32  loader write data.
- `ldr_ack`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid 1 cycle after a read enable.
- `sw_in`  in  16  switch pins.
- `led_out`  out  16  LED register.
- `num_out`  out  32  seven-segment value register.

## Operation
Address decode:
- IO region is `addr[31:12] == 20'hFFFFF`; everything else is memory.
- Within the IO region, only the three parameter addresses are mapped.

State machine: IDLE, ACC, WAIT.
- **IDLE:** if any request is pending, the arbiter grants one. The controller latches addr, we, wdata and the requester ID, then goes to ACC. With no request it stays in IDLE.
- **ACC:**
  - Memory access: `mem_en` = 1, `mem_we` = latched we, and `mem_addr`/`mem_wdata` come from the latches.
  - Memory write: ack the requester, go to IDLE.
  - Memory read: go to WAIT, no ack yet.
  - IO write: update `led_out` (takes `wdata[15:0]`) or `num_out` at the end of the cycle, ack, go to IDLE.
  - IO read: `cpu_rdata` = `{16'h0, sw_in}`, `{16'h0, led_out}` or `num_out`; ack, go to IDLE.
- **WAIT:** `cpu_rdata` = `mem_rdata`, `cpu_ack` = 1, go to IDLE.

Arbitration:
- A priority flag names the preferred requester; reset value is CPU.
- When both requesters are pending in IDLE, the preferred one is granted. After any grant, priority passes to the other requester.
- Loader accesses are always writes (`we` = 1).
- A loader write to the IO region has no side effect but is still acked.

Error and edge cases:
- Unmapped IO address: writes are dropped, reads return 0, and the access is acked normally.
- A store to `SW_ADDR` is dropped and acked.

Outputs default to 0 whenever they are not asserted above.

## Timing
- Request sampled in IDLE at cycle N.
- Store (memory or IO) and IO load: ack at N+1.
- Memory load: ack and data at N+2.
- Back-to-back accesses: the earliest next grant is the cycle after an ack. A requester still holding `req` in that cycle is treated as issuing a new access, so requesters drop `req` the cycle after ack.
- Simultaneous requests: the non-preferred requester waits 2–3 cycles.
- Reset values:
  - State IDLE, priority = CPU.
  - `led_out` = 0, `num_out` = 0.
  - All acks, `mem_en`, `mem_we` = 0.
  - `cpu_rdata` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset mid-access (ACC or WAIT): the access is abandoned; no ack and no IO register update. `led_out`/`num_out` take their reset values.
- Requests are ignored during reset.
- `sw_in` is sampled combinationally in ACC. No synchroniser is included here; the board top supplies one.

## Structure
- Package `mem_io_pkg`:
  - Address constants (IO region prefix, LED/SW/NUM defaults).
  - State enum `{IDLE, ACC, WAIT}`.
  - Requester ID constants (`REQ_CPU`, `REQ_LDR`).
- Sub-module `rr_arb2`: two-requester round-robin arbiter.
  - Inputs: `req[1:0]`, `advance`.
  - Outputs: one-hot `grant`.
  - Holds the priority flag; resets to CPU preference.
- The remaining FSM, decode and IO registers live in `mem_io_ctrl`.

## Test plan
- **CPU store to memory:** `cpu_addr` = 32'h0000_0010, `cpu_wdata` = 32'hDEAD_BEEF. Expect `mem_en`, `mem_we`, `mem_addr` = 32'h10 at N+1; `cpu_ack` at N+1; `cpu_stall` high only at N.
- **CPU load from memory:** 32'h10 with `mem_rdata` model returning 32'hDEAD_BEEF. Expect `cpu_ack` and `cpu_rdata` = 32'hDEAD_BEEF at N+2.
- **IO access:**
  - Store 32'h0000_A5A5 to 32'hFFFF_F000: `led_out` = 16'hA5A5 from N+2.
  - `sw_in` = 16'h1234, load 32'hFFFF_F010: `cpu_rdata` = 32'h0000_1234 at N+1.
  - Load 32'hFFFF_F0F0 (unmapped): 0, acked.
- **Simultaneous requests after reset:** CPU granted first, loader next. Repeat with both held continuously and expect strict alternation CPU, LDR, CPU, LDR.
- **Loader write to IO:** loader writes 32'hFFFF_F020. Expect `ldr_ack` at N+1, `num_out` unchanged, `mem_en` = 0.
- **Reset mid-access:** assert `rst` during WAIT of a memory load. Expect no `cpu_ack`, state IDLE, `led_out`/`num_out` = 0, and the next request serviced normally.
